// File: rtl/wb_stage_buf_pkg.sv
// wb_stage_buf_pkg: shared widths and bus-width helpers for the writeback retire queue
package wb_stage_buf_pkg;
    localparam int WB_DW    = 32;
    localparam int WB_AW    = 5;
    localparam int WB_PCW   = 32;
    localparam int WB_DEPTH = 4;
    localparam int WB_NRD   = 2;
    function automatic int ws_buf_bus_wd(input int aw, input int dw, input int pcw);
        return 1 + aw + dw + pcw;
    endfunction
    function automatic int ws_to_rf_bus_wd(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction
endpackage

// File: rtl/wb_stage_buf_if.sv
// wb_stage_buf_if: MEM->WB handshake, RF write port, forwarding lookups and debug trace
interface wb_stage_buf_if import wb_stage_buf_pkg::*; #(
    parameter int DW  = WB_DW,
    parameter int AW  = WB_AW,
    parameter int PCW = WB_PCW,
    parameter int NRD = WB_NRD
);
    localparam int BUS_WD = ws_buf_bus_wd(AW, DW, PCW);
    localparam int RF_WD  = ws_to_rf_bus_wd(AW, DW);
    logic              ms_to_ws_valid;
    logic [BUS_WD-1:0] ms_to_ws_bus;
    logic              ws_allowin;
    logic              rf_ready;
    logic [RF_WD-1:0]  ws_to_rf_bus;
    logic [NRD*AW-1:0] fwd_raddr;
    logic [NRD-1:0]    fwd_hit;
    logic [NRD*DW-1:0] fwd_data;
    logic              ws_empty;
    logic [PCW-1:0]    debug_wb_pc;
    logic [3:0]        debug_wb_rf_wen;
    logic [AW-1:0]     debug_wb_rf_wnum;
    logic [DW-1:0]     debug_wb_rf_wdata;
    modport slave (
        input  ms_to_ws_valid, ms_to_ws_bus, rf_ready, fwd_raddr,
        output ws_allowin, ws_to_rf_bus, fwd_hit, fwd_data, ws_empty,
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
    modport master (
        output ms_to_ws_valid, ms_to_ws_bus, rf_ready, fwd_raddr,
        input  ws_allowin, ws_to_rf_bus, fwd_hit, fwd_data, ws_empty,
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-first match of one lookup address against the queued RF writes
module wb_fwd_match import wb_stage_buf_pkg::*; #(
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [DEPTH-1:0]         we_i,
    input  logic [AW-1:0]            dest_i [DEPTH],
    input  logic [DW-1:0]            data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [AW-1:0]            raddr_i,
    output logic                     hit_o,
    output logic [DW-1:0]            data_o
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] idx;
    // Walk oldest to youngest so the last match written is the youngest
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (valid_i[idx] && we_i[idx] && dest_i[idx] == raddr_i && raddr_i != '0) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/wb_stage_buf.sv
// wb_stage_buf: in-order retire queue between MEM and the register file with forwarding lookups
module wb_stage_buf import wb_stage_buf_pkg::*; #(
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    parameter int PCW   = WB_PCW,
    parameter int DEPTH = WB_DEPTH,
    parameter int NRD   = WB_NRD
) (
    input logic          clk,
    input logic          resetn,
    wb_stage_buf_if.slave ws
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d, we_q;
    logic [AW-1:0]    dest_q [DEPTH];
    logic [DW-1:0]    res_q [DEPTH];
    logic [PCW-1:0]   pc_q [DEPTH];
    logic             empty, full, pop, push, allowin, rf_we;
    logic [NRD-1:0]    hit;
    logic [NRD*DW-1:0] fdata;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == FULL_CNT;
    assign pop     = !empty && ws.rf_ready;
    assign allowin = !full || pop;
    assign push    = ws.ms_to_ws_valid && allowin;
    assign rf_we   = pop && we_q[head_q];
    // Pop clears before push sets so a full push+pop re-marks the reused slot
    always_comb begin
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(push);
        cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        vld_d  = vld_q;
        if (pop) vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            we_q[tail_q]   <= ws.ms_to_ws_bus[AW+DW+PCW];
            dest_q[tail_q] <= ws.ms_to_ws_bus[DW+PCW +: AW];
            res_q[tail_q]  <= ws.ms_to_ws_bus[PCW +: DW];
            pc_q[tail_q]   <= ws.ms_to_ws_bus[0 +: PCW];
        end
    end
    for (genvar i = 0; i < NRD; i++) begin : g_fwd
        wb_fwd_match #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fwd (
            .valid_i (vld_q),
            .we_i    (we_q),
            .dest_i  (dest_q),
            .data_i  (res_q),
            .head_i  (head_q),
            .raddr_i (ws.fwd_raddr[i*AW +: AW]),
            .hit_o   (hit[i]),
            .data_o  (fdata[i*DW +: DW])
        );
    end
    assign ws.ws_allowin        = allowin;
    assign ws.ws_empty          = empty;
    assign ws.ws_to_rf_bus      = {rf_we, dest_q[head_q], res_q[head_q]};
    assign ws.fwd_hit           = hit;
    assign ws.fwd_data          = fdata;
    assign ws.debug_wb_pc       = pc_q[head_q];
    assign ws.debug_wb_rf_wen   = {4{rf_we}};
    assign ws.debug_wb_rf_wnum  = dest_q[head_q];
    assign ws.debug_wb_rf_wdata = res_q[head_q];
endmodule

// File: tb/tb_wb_stage_buf.sv
// tb_wb_stage_buf: directed scenarios plus a randomized scoreboard run for the retire queue
module tb_wb_stage_buf;
    import wb_stage_buf_pkg::*;
    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    ent_t mq[$];
    always #5 clk = ~clk;
    wb_stage_buf_if ws ();
    wb_stage_buf dut (.clk(clk), .resetn(resetn), .ws(ws.slave));

    function automatic ent_t mk(input logic we, input logic [4:0] dest, input logic [31:0] data, input logic [31:0] pc);
        return {we, dest, data, pc};
    endfunction
    task automatic drive(input logic v, input ent_t e, input logic rdy);
        ws.ms_to_ws_valid = v;
        ws.ms_to_ws_bus   = e;
        ws.rf_ready       = rdy;
        #1;
    endtask
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        ws.fwd_raddr = {5'd1, 5'd1};
        drive(1'b0, '0, 1'b1);
        resetn = 1'b0;
        #1;
        n_cmp++; if (ws.ws_allowin !== 1'b1) begin n_bad++; $display("FAIL rst_allowin got %b exp 1", ws.ws_allowin); end
        n_cmp++; if (ws.ws_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b exp 1", ws.ws_empty); end
        n_cmp++; if (ws.ws_to_rf_bus[37] !== 1'b0) begin n_bad++; $display("FAIL rst_rf_we got %b exp 0", ws.ws_to_rf_bus[37]); end
        n_cmp++; if (ws.fwd_hit !== 2'b00) begin n_bad++; $display("FAIL rst_fwd_hit got %b exp 00", ws.fwd_hit); end
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'h0) begin n_bad++; $display("FAIL rst_wen got %h exp 0", ws.debug_wb_rf_wen); end
        tick();
        resetn = 1'b1;
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_fill;
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, mk(1'b1, 5'(n + 1), 32'(32'h11 * (n + 1)), 32'hbfc00000 + 32'(4 * n)), 1'b0);
            n_cmp++; if (ws.ws_allowin !== 1'b1) begin n_bad++; $display("FAIL fill_allowin[%0d] got %b exp 1", n, ws.ws_allowin); end
            n_cmp++; if (ws.debug_wb_rf_wen !== 4'h0) begin n_bad++; $display("FAIL fill_wen[%0d] got %h exp 0", n, ws.debug_wb_rf_wen); end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.ws_allowin !== 1'b0) begin n_bad++; $display("FAIL full_allowin got %b exp 0", ws.ws_allowin); end
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'h0) begin n_bad++; $display("FAIL full_wen got %h exp 0", ws.debug_wb_rf_wen); end
        n_cmp++; if (ws.debug_wb_pc !== 32'hbfc00000) begin n_bad++; $display("FAIL full_head_pc got %h exp bfc00000", ws.debug_wb_pc); end
        n_cmp++; if (ws.ws_empty !== 1'b0) begin n_bad++; $display("FAIL full_empty got %b exp 0", ws.ws_empty); end
    endtask

    task automatic test_full_push_pop;
        logic [4:0] d [4];
        d = '{5'd2, 5'd3, 5'd4, 5'd6};
        drive(1'b1, mk(1'b1, 5'd6, 32'h66, 32'hbfc00010), 1'b1);
        n_cmp++; if (ws.ws_allowin !== 1'b1) begin n_bad++; $display("FAIL fpp_allowin got %b exp 1", ws.ws_allowin); end
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'hf) begin n_bad++; $display("FAIL fpp_wen got %h exp f", ws.debug_wb_rf_wen); end
        n_cmp++; if (ws.debug_wb_rf_wnum !== 5'd1) begin n_bad++; $display("FAIL fpp_wnum got %0d exp 1", ws.debug_wb_rf_wnum); end
        n_cmp++; if (ws.debug_wb_rf_wdata !== 32'h11) begin n_bad++; $display("FAIL fpp_wdata got %h exp 11", ws.debug_wb_rf_wdata); end
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.ws_allowin !== 1'b0) begin n_bad++; $display("FAIL fpp_still_full got %b exp 0", ws.ws_allowin); end
        n_cmp++; if (ws.debug_wb_pc !== 32'hbfc00004) begin n_bad++; $display("FAIL fpp_head_pc got %h exp bfc00004", ws.debug_wb_pc); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1);
            n_cmp++; if (ws.debug_wb_rf_wnum !== d[k]) begin n_bad++; $display("FAIL drain_wnum[%0d] got %0d exp %0d", k, ws.debug_wb_rf_wnum, d[k]); end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.ws_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b exp 1", ws.ws_empty); end
    endtask

    task automatic test_forward;
        ws.fwd_raddr = {5'd5, 5'd5};
        drive(1'b1, mk(1'b1, 5'd5, 32'hA, 32'h100), 1'b0);
        n_cmp++; if (ws.fwd_hit !== 2'b00) begin n_bad++; $display("FAIL fwd_push_invisible got %b exp 00", ws.fwd_hit); end
        tick();
        drive(1'b1, mk(1'b1, 5'd5, 32'hB, 32'h104), 1'b0);
        n_cmp++; if (ws.fwd_data !== {32'hA, 32'hA}) begin n_bad++; $display("FAIL fwd_older_only got %h exp A,A", ws.fwd_data); end
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.fwd_hit !== 2'b11) begin n_bad++; $display("FAIL fwd_hit got %b exp 11", ws.fwd_hit); end
        n_cmp++; if (ws.fwd_data !== {32'hB, 32'hB}) begin n_bad++; $display("FAIL fwd_youngest got %h exp B,B", ws.fwd_data); end
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (ws.fwd_data !== {32'hB, 32'hB}) begin n_bad++; $display("FAIL fwd_during_pop got %h exp B,B", ws.fwd_data); end
        tick();
        ws.fwd_raddr = {5'd5, 5'd0};
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.fwd_hit !== 2'b10) begin n_bad++; $display("FAIL fwd_r0_hit got %b exp 10", ws.fwd_hit); end
        n_cmp++; if (ws.fwd_data !== {32'hB, 32'h0}) begin n_bad++; $display("FAIL fwd_r0_data got %h exp B,0", ws.fwd_data); end
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (ws.fwd_hit !== 2'b10) begin n_bad++; $display("FAIL fwd_popped_visible got %b exp 10", ws.fwd_hit); end
        tick();
        drive(1'b1, mk(1'b1, 5'd0, 32'hC, 32'h108), 1'b0);
        n_cmp++; if (ws.fwd_hit !== 2'b00 || ws.fwd_data !== 64'h0) begin n_bad++; $display("FAIL fwd_empty got %b/%h exp 00/0", ws.fwd_hit, ws.fwd_data); end
        tick();
        ws.fwd_raddr = {5'd0, 5'd0};
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.fwd_hit !== 2'b00) begin n_bad++; $display("FAIL fwd_dest0 got %b exp 00", ws.fwd_hit); end
        drive(1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_no_we;
        ws.fwd_raddr = {5'd7, 5'd7};
        drive(1'b1, mk(1'b0, 5'd7, 32'h77, 32'h200), 1'b0);
        tick();
        drive(1'b1, mk(1'b1, 5'd7, 32'h70, 32'h204), 1'b0);
        n_cmp++; if (ws.fwd_hit !== 2'b00) begin n_bad++; $display("FAIL nowe_not_fwd got %b exp 00", ws.fwd_hit); end
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'h0) begin n_bad++; $display("FAIL nowe_wen got %h exp 0", ws.debug_wb_rf_wen); end
        n_cmp++; if (ws.debug_wb_pc !== 32'h200) begin n_bad++; $display("FAIL nowe_pc got %h exp 200", ws.debug_wb_pc); end
        n_cmp++; if (ws.fwd_data !== {32'h70, 32'h70}) begin n_bad++; $display("FAIL nowe_fwd_young got %h exp 70,70", ws.fwd_data); end
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (ws.debug_wb_pc !== 32'h204) begin n_bad++; $display("FAIL nowe_pc_adv got %h exp 204", ws.debug_wb_pc); end
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'hf) begin n_bad++; $display("FAIL nowe_next_wen got %h exp f", ws.debug_wb_rf_wen); end
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.ws_empty !== 1'b1) begin n_bad++; $display("FAIL nowe_empty got %b exp 1", ws.ws_empty); end
    endtask

    task automatic test_async_reset;
        ws.fwd_raddr = {5'd9, 5'd9};
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, mk(1'b1, 5'd9, 32'(n), 32'h300 + 32'(4 * n)), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (ws.ws_empty !== 1'b1) begin n_bad++; $display("FAIL arst_empty got %b exp 1", ws.ws_empty); end
        n_cmp++; if (ws.ws_allowin !== 1'b1) begin n_bad++; $display("FAIL arst_allowin got %b exp 1", ws.ws_allowin); end
        n_cmp++; if (ws.fwd_hit !== 2'b00) begin n_bad++; $display("FAIL arst_fwd_hit got %b exp 00", ws.fwd_hit); end
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'h0) begin n_bad++; $display("FAIL arst_wen got %h exp 0", ws.debug_wb_rf_wen); end
        tick();
        resetn = 1'b1;
        drive(1'b1, mk(1'b1, 5'd9, 32'h99, 32'h400), 1'b0);
        tick();
        drive(1'b0, '0, 1'b1);
        n_cmp++; if (ws.debug_wb_rf_wen !== 4'hf || ws.debug_wb_rf_wnum !== 5'd9) begin n_bad++; $display("FAIL arst_retire got %h/%0d exp f/9", ws.debug_wb_rf_wen, ws.debug_wb_rf_wnum); end
        n_cmp++; if (ws.debug_wb_rf_wdata !== 32'h99 || ws.debug_wb_pc !== 32'h400) begin n_bad++; $display("FAIL arst_retire_data got %h/%h exp 99/400", ws.debug_wb_rf_wdata, ws.debug_wb_pc); end
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (ws.ws_empty !== 1'b1) begin n_bad++; $display("FAIL arst_empty_after got %b exp 1", ws.ws_empty); end
    endtask

    task automatic test_random;
        ent_t e, h;
        logic v, r, pop_m, alw, eh;
        logic [4:0] ra;
        logic [31:0] ed;
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            e = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            v = $urandom_range(0, 9) < 6;
            r = 1'($urandom_range(0, 1));
            ws.fwd_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            drive(v, e, r);
            pop_m = mq.size() > 0 && r;
            alw = mq.size() < 4 || pop_m;
            n_cmp++; if (ws.ws_allowin !== alw) begin n_bad++; $display("FAIL rnd_allowin c%0d got %b exp %b", c, ws.ws_allowin, alw); end
            n_cmp++; if (ws.ws_empty !== (mq.size() == 0)) begin n_bad++; $display("FAIL rnd_empty c%0d got %b exp %b", c, ws.ws_empty, mq.size() == 0); end
            n_cmp++; if (ws.debug_wb_rf_wen !== {4{pop_m && mq[0].we}}) begin n_bad++; $display("FAIL rnd_wen c%0d got %h exp %h", c, ws.debug_wb_rf_wen, {4{pop_m && mq[0].we}}); end
            if (mq.size() > 0) begin
                h = mq[0];
                n_cmp++; if ({ws.debug_wb_pc, ws.debug_wb_rf_wnum, ws.debug_wb_rf_wdata} !== {h.pc, h.dest, h.data}) begin n_bad++; $display("FAIL rnd_head c%0d got %h/%0d/%h exp %h/%0d/%h", c, ws.debug_wb_pc, ws.debug_wb_rf_wnum, ws.debug_wb_rf_wdata, h.pc, h.dest, h.data); end
            end
            for (int p = 0; p < 2; p++) begin
                ra = ws.fwd_raddr[p*5 +: 5];
                eh = 1'b0;
                ed = '0;
                foreach (mq[j]) if (mq[j].we && mq[j].dest == ra && ra != 5'd0) begin eh = 1'b1; ed = mq[j].data; end
                n_cmp++; if (ws.fwd_hit[p] !== eh || ws.fwd_data[p*32 +: 32] !== ed) begin n_bad++; $display("FAIL rnd_fwd c%0d p%0d got %b/%h exp %b/%h", c, p, ws.fwd_hit[p], ws.fwd_data[p*32 +: 32], eh, ed); end
            end
            tick();
            if (pop_m) void'(mq.pop_front());
            if (v && alw) mq.push_back(e);
        end
        drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        ws.ms_to_ws_valid = 1'b0;
        ws.ms_to_ws_bus   = '0;
        ws.rf_ready       = 1'b0;
        ws.fwd_raddr      = '0;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_forward();
        test_no_we();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
